// File: rtl/rf_wport_sched_pkg.sv
// Shared register-file types and constants for the write-port scheduler.
// Pure declarations: no timing, no flow control.
package rf_wport_sched_pkg;

  localparam int RegNum = 32;

  typedef logic [4:0]  RegAddrBus;
  typedef logic [31:0] RegBus;

  localparam RegBus     ZeroWord     = '0;
  localparam logic      WriteEnable  = 1'b1;
  localparam logic      WriteDisable = 1'b0;
  localparam RegAddrBus NOPRegAddr   = '0;
  localparam logic      RstEnable    = 1'b1;
  localparam logic      StallReq     = 1'b1;
  localparam logic      NoStallReq   = 1'b0;

  typedef struct packed {
    RegAddrBus waddr;
    RegBus     wdata;
  } llu_ent_t;

  localparam int LLU_ENT_W = $bits(llu_ent_t);

  function automatic logic [RegNum-1:0] addr_onehot(input RegAddrBus a);
    addr_onehot    = '0;
    addr_onehot[a] = 1'b1;
  endfunction

endpackage

// File: rtl/rf_sync_fifo.sv
// Synchronous FIFO; head visible the cycle after the push, pop consumes at the clock edge.
// Push ignored when full and pop ignored when empty; count reflects the registered state.
module rf_sync_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers are power-of-two wide, so increment wraps modulo DEPTH for free.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = wptr_q + PTR_W'(1);
    if (do_pop)  rptr_d = rptr_q + PTR_W'(1);
    if (do_push && !do_pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (!do_push && do_pop) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/rf_wport_sched.sv
// RF write-port arbiter: WB has priority, buffered LLU results drain into idle slots 1 cycle after push.
// LLU backpressured via llu_ready when the FIFO is full; ID stalled on hazards with pending LLU writes.
module rf_wport_sched
  import rf_wport_sched_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_we,
  input  logic [4:0]       wb_waddr,
  input  logic [31:0]      wb_wdata,
  input  logic             llu_valid,
  input  logic [4:0]       llu_waddr,
  input  logic [31:0]      llu_wdata,
  output logic             llu_ready,
  input  logic             iss_valid,
  input  logic [4:0]       iss_waddr,
  input  logic             id_re1,
  input  logic [4:0]       id_raddr1,
  input  logic             id_re2,
  input  logic [4:0]       id_raddr2,
  output logic             stall_req,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic [CNT_W-1:0] fifo_count,
  output logic [31:0]      pend_o
);

  llu_ent_t          push_ent, head;
  logic [LLU_ENT_W-1:0] head_raw;
  logic              in_rst, fifo_full, fifo_empty, do_push, do_pop;
  logic [CNT_W-1:0]  cnt_raw;
  logic [RegNum-1:0] pend_q, pend_d, pend_eff;

  assign in_rst    = (rst == RstEnable);
  assign llu_ready = !in_rst && (cnt_raw < CNT_W'(DEPTH));
  assign do_push   = llu_valid && llu_ready && (llu_waddr != NOPRegAddr);
  assign do_pop    = !in_rst && !wb_we && !fifo_empty;
  assign push_ent  = '{waddr: llu_waddr, wdata: llu_wdata};
  assign head      = llu_ent_t'(head_raw);

  rf_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (LLU_ENT_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (in_rst),
    .push_i  (do_push),
    .pop_i   (do_pop),
    .wdata_i (push_ent),
    .rdata_o (head_raw),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (cnt_raw)
  );

  always_comb begin
    rf_we    = WriteDisable;
    rf_waddr = NOPRegAddr;
    rf_wdata = ZeroWord;
    if (!in_rst) begin
      if (wb_we) begin
        rf_we    = WriteEnable;
        rf_waddr = wb_waddr;
        rf_wdata = wb_wdata;
      end else if (!fifo_empty) begin
        rf_we    = WriteEnable;
        rf_waddr = head.waddr;
        rf_wdata = head.wdata;
      end
    end
  end

  // The register being drained is already safe to read: the WB bypass forwards it.
  assign pend_eff = pend_q & ~(do_pop ? addr_onehot(head.waddr) : '0);

  always_comb begin
    stall_req = NoStallReq;
    if (!in_rst && ((id_re1 && pend_eff[id_raddr1]) ||
                    (id_re2 && pend_eff[id_raddr2]) ||
                    (iss_valid && pend_eff[iss_waddr])))
      stall_req = StallReq;
  end

  always_comb begin
    pend_d = pend_eff;
    if (iss_valid && (stall_req == NoStallReq) && (iss_waddr != NOPRegAddr))
      pend_d = pend_d | addr_onehot(iss_waddr);
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (in_rst) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  assign fifo_count = in_rst ? '0 : cnt_raw;
  assign pend_o     = in_rst ? '0 : pend_q;

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_rf_wport_sched.sv
// Self-checking bench for rf_wport_sched: directed vector table, corner sequences, random vs queue model.
module tb_rf_wport_sched;

  localparam int DEPTH = 2;
  localparam int CNT_W = 2;

  logic        clk = 1'b0;
  logic        rst, wb_we, llu_valid, llu_ready, iss_valid, id_re1, id_re2;
  logic        stall_req, rf_we;
  logic [4:0]  wb_waddr, llu_waddr, iss_waddr, id_raddr1, id_raddr2, rf_waddr;
  logic [31:0] wb_wdata, llu_wdata, rf_wdata, pend_o;
  logic [CNT_W-1:0] fifo_count;

  always #5 clk = ~clk;

  rf_wport_sched #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .llu_valid(llu_valid), .llu_waddr(llu_waddr), .llu_wdata(llu_wdata), .llu_ready(llu_ready),
    .iss_valid(iss_valid), .iss_waddr(iss_waddr),
    .id_re1(id_re1), .id_raddr1(id_raddr1), .id_re2(id_re2), .id_raddr2(id_raddr2),
    .stall_req(stall_req), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fifo_count(fifo_count), .pend_o(pend_o)
  );

  typedef struct {
    logic        rst, wbwe;
    logic [4:0]  wba;
    logic [31:0] wbd;
    logic        lv;
    logic [4:0]  la;
    logic [31:0] ld;
    logic        iv;
    logic [4:0]  ia;
    logic        r1;
    logic [4:0]  a1;
    logic        r2;
    logic [4:0]  a2;
    logic        erdy, estall, ewe;
    logic [4:0]  ewa;
    logic [31:0] ewd;
    logic [1:0]  ecnt;
    logic [31:0] epend;
  } vec_t;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  logic [36:0] mq[$];
  logic [31:0] mpend;

  function automatic vec_t mk(
    input logic r, input logic wbwe, input logic [4:0] wba, input logic [31:0] wbd,
    input logic lv, input logic [4:0] la, input logic [31:0] ld,
    input logic iv, input logic [4:0] ia,
    input logic r1, input logic [4:0] a1, input logic r2, input logic [4:0] a2,
    input logic erdy, input logic estall, input logic ewe, input logic [4:0] ewa,
    input logic [31:0] ewd, input logic [1:0] ecnt, input logic [31:0] epend);
    vec_t v;
    v.rst = r; v.wbwe = wbwe; v.wba = wba; v.wbd = wbd;
    v.lv = lv; v.la = la; v.ld = ld; v.iv = iv; v.ia = ia;
    v.r1 = r1; v.a1 = a1; v.r2 = r2; v.a2 = a2;
    v.erdy = erdy; v.estall = estall; v.ewe = ewe; v.ewa = ewa;
    v.ewd = ewd; v.ecnt = ecnt; v.epend = epend;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic apply_chk(input vec_t v, input string tag);
    rst = v.rst; wb_we = v.wbwe; wb_waddr = v.wba; wb_wdata = v.wbd;
    llu_valid = v.lv; llu_waddr = v.la; llu_wdata = v.ld;
    iss_valid = v.iv; iss_waddr = v.ia;
    id_re1 = v.r1; id_raddr1 = v.a1; id_re2 = v.r2; id_raddr2 = v.a2;
    @(negedge clk);
    check({tag, ".llu_ready"},  {31'd0, llu_ready}, {31'd0, v.erdy});
    check({tag, ".stall_req"},  {31'd0, stall_req}, {31'd0, v.estall});
    check({tag, ".rf_we"},      {31'd0, rf_we},     {31'd0, v.ewe});
    check({tag, ".rf_waddr"},   {27'd0, rf_waddr},  {27'd0, v.ewa});
    check({tag, ".rf_wdata"},   rf_wdata,           v.ewd);
    check({tag, ".fifo_count"}, {30'd0, fifo_count}, {30'd0, v.ecnt});
    check({tag, ".pend_o"},     pend_o,             v.epend);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Reference model: FIFO as a queue, scoreboard as a bit vector, outputs from the rules directly.
  task automatic model_eval(inout vec_t v);
    logic [31:0] eff;
    logic        pop;
    v.erdy = 0; v.estall = 0; v.ewe = 0; v.ewa = 0; v.ewd = 0; v.ecnt = 0; v.epend = 0;
    if (!v.rst) begin
      v.erdy  = (mq.size() < DEPTH);
      v.ecnt  = 2'(mq.size());
      v.epend = mpend;
      pop = !v.wbwe && (mq.size() > 0);
      if (v.wbwe) begin
        v.ewe = 1; v.ewa = v.wba; v.ewd = v.wbd;
      end else if (mq.size() > 0) begin
        v.ewe = 1; v.ewa = mq[0][36:32]; v.ewd = mq[0][31:0];
      end
      eff = mpend;
      if (pop) eff[mq[0][36:32]] = 1'b0;
      v.estall = (v.r1 && eff[v.a1]) || (v.r2 && eff[v.a2]) || (v.iv && eff[v.ia]);
    end
  endtask

  task automatic model_update(input vec_t v);
    if (v.rst) begin
      mq.delete();
      mpend = '0;
    end else begin
      if (!v.wbwe && mq.size() > 0) begin
        mpend[mq[0][36:32]] = 1'b0;
        void'(mq.pop_front());
      end
      if (v.lv && v.erdy && v.la != 0) mq.push_back({v.la, v.ld});
      if (v.iv && !v.estall && v.ia != 0) mpend[v.ia] = 1'b1;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];
    vec_t v;

    rst = 1; wb_we = 0; wb_waddr = 0; wb_wdata = 0; llu_valid = 0; llu_waddr = 0; llu_wdata = 0;
    iss_valid = 0; iss_waddr = 0; id_re1 = 0; id_raddr1 = 0; id_re2 = 0; id_raddr2 = 0;
    mpend = '0;
    @(posedge clk);
    #1;

    // rst, wbwe,wba,wbd, lv,la,ld, iv,ia, r1,a1,r2,a2 | rdy,stall,we,wa,wd,cnt,pend
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1, 1,3,'h77, 1,4,'h55, 0,0, 0,0,0,0,  0,0,0,0,0,0,0));
    tbl.push_back(mk(0, 0,0,0,      0,0,0,      0,0, 0,0,0,0,  1,0,0,0,0,0,0));
    tbl.push_back(mk(0, 0,0,0,      0,0,0,      1,5, 0,0,0,0,  1,0,0,0,0,0,0));
    tbl.push_back(mk(0, 0,0,0,      1,5,'h1234, 0,0, 0,0,0,0,  1,0,0,0,0,0,'h20));
    tbl.push_back(mk(0, 0,0,0,      0,0,0,      0,0, 1,5,0,0,  1,0,1,5,'h1234,1,'h20));
    tbl.push_back(mk(0, 0,0,0,      0,0,0,      0,0, 0,0,0,0,  1,0,0,0,0,0,0));
    tbl.push_back(mk(0, 1,3,'h33,   1,7,'hAA,   0,0, 0,0,0,0,  1,0,1,3,'h33,0,0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 1,3,'h33, 0,0,0,      0,0, 0,0,0,0,  1,0,1,3,'h33,1,0));
    tbl.push_back(mk(0, 0,0,0,      0,0,0,      0,0, 0,0,0,0,  1,0,1,7,'hAA,1,0));
    tbl.push_back(mk(0, 0,0,0,      0,0,0,      0,0, 0,0,0,0,  1,0,0,0,0,0,0));
    tbl.push_back(mk(0, 1,3,'h33,   1,10,'h100, 0,0, 0,0,0,0,  1,0,1,3,'h33,0,0));
    tbl.push_back(mk(0, 1,3,'h33,   1,11,'h101, 0,0, 0,0,0,0,  1,0,1,3,'h33,1,0));
    tbl.push_back(mk(0, 1,3,'h33,   1,12,'h102, 0,0, 0,0,0,0,  0,0,1,3,'h33,2,0));
    tbl.push_back(mk(0, 0,0,0,      1,12,'h102, 0,0, 0,0,0,0,  0,0,1,10,'h100,2,0));
    tbl.push_back(mk(0, 0,0,0,      1,12,'h102, 0,0, 0,0,0,0,  1,0,1,11,'h101,1,0));
    tbl.push_back(mk(0, 0,0,0,      0,0,0,      0,0, 0,0,0,0,  1,0,1,12,'h102,1,0));
    tbl.push_back(mk(0, 0,0,0,      0,0,0,      0,0, 0,0,0,0,  1,0,0,0,0,0,0));
    tbl.push_back(mk(0, 0,0,0,      1,0,'hDEAD, 0,0, 0,0,0,0,  1,0,0,0,0,0,0));
    tbl.push_back(mk(0, 0,0,0,      0,0,0,      0,0, 0,0,0,0,  1,0,0,0,0,0,0));
    foreach (tbl[i]) apply_chk(tbl[i], $sformatf("tbl%0d", i));

    // RAW stall against pending $9, released in the drain cycle.
    apply_chk(mk(0, 0,0,0, 0,0,0,      1,9, 0,0,0,0, 1,0,0,0,0,0,0),          "raw0");
    apply_chk(mk(0, 1,3,1, 1,9,'h999,  0,0, 0,0,1,9, 1,1,1,3,1,0,'h200),      "raw1");
    apply_chk(mk(0, 1,3,1, 0,0,0,      0,0, 0,0,1,9, 1,1,1,3,1,1,'h200),      "raw2");
    apply_chk(mk(0, 0,0,0, 0,0,0,      0,0, 0,0,1,9, 1,0,1,9,'h999,1,'h200),  "raw3");
    apply_chk(mk(0, 0,0,0, 0,0,0,      0,0, 0,0,1,9, 1,0,0,0,0,0,0),          "raw4");

    // WAW stall, then issue of $9 in the cycle $9 drains: set wins over clear.
    apply_chk(mk(0, 0,0,0, 0,0,0,      1,9, 0,0,0,0, 1,0,0,0,0,0,0),          "waw0");
    apply_chk(mk(0, 0,0,0, 0,0,0,      1,9, 0,0,0,0, 1,1,0,0,0,0,'h200),      "waw1");
    apply_chk(mk(0, 1,3,2, 1,9,'h42,   0,0, 0,0,0,0, 1,0,1,3,2,0,'h200),      "waw2");
    apply_chk(mk(0, 0,0,0, 0,0,0,      1,9, 0,0,0,0, 1,0,1,9,'h42,1,'h200),   "waw3");
    apply_chk(mk(0, 0,0,0, 0,0,0,      0,0, 1,9,0,0, 1,1,0,0,0,0,'h200),      "waw4");

    // Mid-operation reset discards the buffered result and pending bits.
    apply_chk(mk(0, 1,3,2, 1,4,'h5,    0,0, 0,0,0,0, 1,0,1,3,2,0,'h200),      "mrst0");
    apply_chk(mk(1, 0,0,0, 0,0,0,      0,0, 0,0,0,0, 0,0,0,0,0,0,0),          "mrst1");
    apply_chk(mk(0, 0,0,0, 0,0,0,      0,0, 0,0,0,0, 1,0,0,0,0,0,0),          "mrst2");

    // Random traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      v = mk(0, 0,0,0, 0,0,0, 0,0, 0,0,0,0, 0,0,0,0,0,0,0);
      v.rst  = (i < 2) || ($urandom_range(0, 99) == 0);
      v.wbwe = ($urandom_range(0, 1) == 1);
      v.wba  = 5'($urandom_range(0, 7));
      v.wbd  = $urandom;
      v.lv   = ($urandom_range(0, 1) == 1);
      v.la   = 5'($urandom_range(0, 7));
      v.ld   = $urandom;
      v.iv   = ($urandom_range(0, 2) == 0);
      v.ia   = 5'($urandom_range(0, 7));
      v.r1   = ($urandom_range(0, 1) == 1);
      v.a1   = 5'($urandom_range(0, 7));
      v.r2   = ($urandom_range(0, 1) == 1);
      v.a2   = 5'($urandom_range(0, 7));
      model_eval(v);
      apply_chk(v, "rnd");
      model_update(v);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
